// File: rtl/gpio_param_bank.sv
// Parameter bank behind a toggle-handshake GPIO command port.
// Commands read/write per-slot parameters and read name/status words.
module gpio_param_bank #(
    parameter int GPIO_WIDTH = 32,
    parameter int PARAM_COUNT = 16,
    parameter logic [PARAM_COUNT-1:0] WRITE_MASK = {PARAM_COUNT{1'b1}},
    parameter logic [GPIO_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [GPIO_WIDTH-1:0]             GP_IN,
    input  logic [GPIO_WIDTH-1:0]             GP_DATA_IN,
    input  logic [3:0]                        SET,
    input  logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_STATUS,
    input  logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_NAME,
    output logic [GPIO_WIDTH-1:0]             GP_OUT,
    output logic                              GP_ACK,
    output logic                              GP_ERR,
    output logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_OUT,
    output logic [PARAM_COUNT-1:0]            PARAM_UPDATE,
    output logic                              BUSY
);

    localparam int W = GPIO_WIDTH;
    localparam int N = PARAM_COUNT;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_NAME = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_STAT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_EXEC,
        S_ACK
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     sync_q, sync_d;
    logic           acc_q, acc_d;
    logic [1:0]     op_q, op_d;
    logic [3:0]     sel_q, sel_d;
    logic [3:0]     idx_q, idx_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   gp_out_q, gp_out_d;
    logic           ack_q, ack_d;
    logic           err_q, err_d;
    logic [N*W-1:0] params_q, params_d;
    logic [N-1:0]   upd_q, upd_d;

    logic [W-1:0]   slot_par, slot_name, slot_stat;
    logic           slot_wm;
    logic           match;
    logic           idx_ok;
    logic           unused_gp;

    // Payload bits between the set select and the index carry no meaning
    assign unused_gp = ^GP_IN[W-8:4];

    assign match  = (sel_q == SET);
    assign idx_ok = ({1'b0, idx_q} < 5'(N));

    always_comb begin
        slot_par  = '0;
        slot_name = '0;
        slot_stat = '0;
        slot_wm   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == 4'(i)) begin
                slot_par  = params_q[i*W +: W];
                slot_name = PARAMS_NAME[i*W +: W];
                slot_stat = PARAMS_STATUS[i*W +: W];
                slot_wm   = WRITE_MASK[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sync_d   = {sync_q[0], GP_IN[W-1]};
        acc_d    = acc_q;
        op_d     = op_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        data_d   = data_q;
        gp_out_d = gp_out_q;
        ack_d    = ack_q;
        err_d    = err_q;
        params_d = params_q;
        upd_d    = '0;
        unique case (state_q)
            S_IDLE: begin
                if (sync_q[1] != acc_q) begin
                    acc_d   = sync_q[1];
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                op_d    = GP_IN[W-2:W-3];
                sel_d   = GP_IN[W-4:W-7];
                idx_d   = GP_IN[3:0];
                data_d  = GP_DATA_IN;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_ACK;
                if (match) begin
                    ack_d = ~ack_q;
                    if (!idx_ok || (op_q == OP_WR && !slot_wm)) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        unique case (op_q)
                            OP_RD:   gp_out_d = slot_par;
                            OP_NAME: gp_out_d = slot_name;
                            OP_STAT: gp_out_d = slot_stat;
                            OP_WR: begin
                                gp_out_d = data_q;
                                for (int i = 0; i < N; i++) begin
                                    if (idx_q == 4'(i)) begin
                                        params_d[i*W +: W] = data_q;
                                        upd_d[i] = 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
            S_ACK: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            acc_q    <= 1'b0;
            op_q     <= '0;
            sel_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            gp_out_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            params_q <= {N{RESET_VALUE}};
            upd_q    <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            gp_out_q <= gp_out_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            params_q <= params_d;
            upd_q    <= upd_d;
        end
    end

    assign GP_OUT       = gp_out_q;
    assign GP_ACK       = ack_q;
    assign GP_ERR       = err_q;
    assign PARAMS_OUT   = params_q;
    assign PARAM_UPDATE = upd_q;
    assign BUSY         = (state_q != S_IDLE);

endmodule
